// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register ids and the
// decoded register-id bundle handed from decode to execute.
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // Register ids
   localparam logic [3:0]  RNONE       = 4'hF;
   localparam int unsigned RSP_DEFAULT = 4;
   localparam int unsigned ID_W        = 4;

   // Decoded source/destination ids for one instruction
   typedef struct packed {
      logic [ID_W-1:0] src_a;
      logic [ID_W-1:0] src_b;
      logic [ID_W-1:0] dst_e;
      logic [ID_W-1:0] dst_m;
   } dec_ids_t;

endpackage

// File: rtl/regfile_2r2w.sv
// Register file, NREGS x DATA_W, two combinational read ports and two write
// ports (E, M) with write-through bypass. Port M has priority on both the
// stored value and the bypass when both ports target the same id.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_raddr_a/b   [3:0]          read ids
//   o_rdata_a_c/b_c [DATA_W-1:0] combinational read data (0 for RNONE / out of range)
//   i_we_e, i_wdst_e, i_wval_e   write port E
//   i_we_m, i_wdst_m, i_wval_m   write port M
module regfile_2r2w #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NREGS    = 15,
   parameter int unsigned INIT_IDX = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        i_raddr_a,
   input  logic [3:0]        i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a_c,
   output logic [DATA_W-1:0] o_rdata_b_c,
   input  logic              i_we_e,
   input  logic [3:0]        i_wdst_e,
   input  logic [DATA_W-1:0] i_wval_e,
   input  logic              i_we_m,
   input  logic [3:0]        i_wdst_m,
   input  logic [DATA_W-1:0] i_wval_m
);

   localparam logic [3:0] ID_LIMIT = 4'(NREGS);

   logic [DATA_W-1:0] r_regs [NREGS];

   // One flop group per register; M checked first so it wins a shared dst.
   // Ids outside 0..NREGS-1 (incl. RNONE) match no entry and are dropped.
   for (genvar g = 0; g < NREGS; g++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            r_regs[g] <= (INIT_IDX != 0) ? DATA_W'(g) : '0;
         else if (i_we_m && (i_wdst_m == 4'(g)))
            r_regs[g] <= i_wval_m;
         else if (i_we_e && (i_wdst_e == 4'(g)))
            r_regs[g] <= i_wval_e;
      end
   end

   // Read with write-through bypass, M before E
   assign o_rdata_a_c = (i_raddr_a >= ID_LIMIT)                ? '0       :
                        (i_we_m && (i_wdst_m == i_raddr_a))    ? i_wval_m :
                        (i_we_e && (i_wdst_e == i_raddr_a))    ? i_wval_e :
                                                                 r_regs[i_raddr_a];

   assign o_rdata_b_c = (i_raddr_b >= ID_LIMIT)                ? '0       :
                        (i_we_m && (i_wdst_m == i_raddr_b))    ? i_wval_m :
                        (i_we_e && (i_wdst_e == i_raddr_b))    ? i_wval_e :
                                                                 r_regs[i_raddr_b];

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: selects srcA/srcB/dstE/dstM from icode/rA/rB, reads
// both operands from the register file (with writeback bypass) and registers
// the bundle into the D->E pipeline register under stall/bubble control.
// Ports:
//   clk, rst                         clock, async active-high reset
//   d_icode, d_rA, d_rB   [3:0]      decode-stage instruction fields
//   e_stall, e_bubble                E register hold / NOP insert (stall wins)
//   we_e, wdst_e, wval_e             writeback port E (ALU result)
//   we_m, wdst_m, wval_m             writeback port M (memory result)
//   e_icode, e_srcA, e_srcB,
//   e_dstE, e_dstM        [3:0]      registered icode and ids
//   e_valA, e_valB        [DATA_W-1:0] registered operands
module decode_regfile
   import y86_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned NREGS    = 15,
   parameter int unsigned RSP_ID   = RSP_DEFAULT,
   parameter int unsigned INIT_IDX = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        d_icode,
   input  logic [3:0]        d_rA,
   input  logic [3:0]        d_rB,
   input  logic              e_stall,
   input  logic              e_bubble,
   input  logic              we_e,
   input  logic [3:0]        wdst_e,
   input  logic [DATA_W-1:0] wval_e,
   input  logic              we_m,
   input  logic [3:0]        wdst_m,
   input  logic [DATA_W-1:0] wval_m,
   output logic [3:0]        e_icode,
   output logic [DATA_W-1:0] e_valA,
   output logic [DATA_W-1:0] e_valB,
   output logic [3:0]        e_srcA,
   output logic [3:0]        e_srcB,
   output logic [3:0]        e_dstE,
   output logic [3:0]        e_dstM
);

   localparam logic [3:0] RSP = 4'(RSP_ID);

   dec_ids_t          w_ids;
   logic [DATA_W-1:0] w_val_a;
   logic [DATA_W-1:0] w_val_b;

   dec_ids_t          r_ids;
   logic [3:0]        r_icode;
   logic [DATA_W-1:0] r_val_a;
   logic [DATA_W-1:0] r_val_b;

   // Source/destination selection; unused fields and unknown icodes stay RNONE
   always_comb begin
      w_ids.src_a = RNONE;
      w_ids.src_b = RNONE;
      w_ids.dst_e = RNONE;
      w_ids.dst_m = RNONE;
      case (d_icode)
         I_RRMOVQ: begin
            w_ids.src_a = d_rA;
            w_ids.dst_e = d_rB;
         end
         I_IRMOVQ: w_ids.dst_e = d_rB;
         I_RMMOVQ: begin
            w_ids.src_a = d_rA;
            w_ids.src_b = d_rB;
         end
         I_MRMOVQ: begin
            w_ids.src_b = d_rB;
            w_ids.dst_m = d_rA;
         end
         I_OPQ: begin
            w_ids.src_a = d_rA;
            w_ids.src_b = d_rB;
            w_ids.dst_e = d_rB;
         end
         I_CALL: begin
            w_ids.src_b = RSP;
            w_ids.dst_e = RSP;
         end
         I_RET: begin
            w_ids.src_a = RSP;
            w_ids.src_b = RSP;
            w_ids.dst_e = RSP;
         end
         I_PUSHQ: begin
            w_ids.src_a = d_rA;
            w_ids.src_b = RSP;
            w_ids.dst_e = RSP;
         end
         I_POPQ: begin
            w_ids.src_a = RSP;
            w_ids.src_b = RSP;
            w_ids.dst_e = RSP;
            w_ids.dst_m = d_rA;
         end
         default: ;
      endcase
   end

   regfile_2r2w #(
      .DATA_W   (DATA_W),
      .NREGS    (NREGS),
      .INIT_IDX (INIT_IDX)
   ) u_regfile (
      .clk         (clk),
      .rst         (rst),
      .i_raddr_a   (w_ids.src_a),
      .i_raddr_b   (w_ids.src_b),
      .o_rdata_a_c (w_val_a),
      .o_rdata_b_c (w_val_b),
      .i_we_e      (we_e),
      .i_wdst_e    (wdst_e),
      .i_wval_e    (wval_e),
      .i_we_m      (we_m),
      .i_wdst_m    (wdst_m),
      .i_wval_m    (wval_m)
   );

   // D->E pipeline register; stall has priority over bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_icode <= I_NOP;
         r_ids   <= '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
         r_val_a <= '0;
         r_val_b <= '0;
      end else if (e_stall) begin
         r_icode <= r_icode;
      end else if (e_bubble) begin
         r_icode <= I_NOP;
         r_ids   <= '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
         r_val_a <= '0;
         r_val_b <= '0;
      end else begin
         r_icode <= d_icode;
         r_ids   <= w_ids;
         r_val_a <= w_val_a;
         r_val_b <= w_val_b;
      end
   end

   assign e_icode = r_icode;
   assign e_valA  = r_val_a;
   assign e_valB  = r_val_b;
   assign e_srcA  = r_ids.src_a;
   assign e_srcB  = r_ids.src_b;
   assign e_dstE  = r_ids.dst_e;
   assign e_dstM  = r_ids.dst_m;

endmodule

// File: tb/tb_decode_regfile.sv
// Self-checking bench for decode_regfile (NREGS=14 so id 14 is out of range).
module tb_decode_regfile;

   localparam int unsigned DW   = 64;
   localparam int unsigned NR   = 14;
   localparam logic [3:0]  RSP  = 4'h4;

   logic          clk;
   logic          rst;
   logic [3:0]    d_icode, d_rA, d_rB;
   logic          e_stall, e_bubble;
   logic          we_e, we_m;
   logic [3:0]    wdst_e, wdst_m;
   logic [DW-1:0] wval_e, wval_m;
   logic [3:0]    e_icode, e_srcA, e_srcB, e_dstE, e_dstM;
   logic [DW-1:0] e_valA, e_valB;

   int n_vec = 0;
   int n_err = 0;
   logic en = 1'b0;

   decode_regfile #(.DATA_W(DW), .NREGS(NR), .RSP_ID(4), .INIT_IDX(1)) dut (
      .clk(clk), .rst(rst),
      .d_icode(d_icode), .d_rA(d_rA), .d_rB(d_rB),
      .e_stall(e_stall), .e_bubble(e_bubble),
      .we_e(we_e), .wdst_e(wdst_e), .wval_e(wval_e),
      .we_m(we_m), .wdst_m(wdst_m), .wval_m(wval_m),
      .e_icode(e_icode), .e_valA(e_valA), .e_valB(e_valB),
      .e_srcA(e_srcA), .e_srcB(e_srcB), .e_dstE(e_dstE), .e_dstM(e_dstM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_regs [16];
   logic [3:0]    x_icode, x_srcA, x_srcB, x_dstE, x_dstM;
   logic [DW-1:0] x_valA, x_valB;

   function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return RSP;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return RSP;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [DW-1:0] m_rd(input logic [3:0] id);
      if (int'(id) >= NR) return '0;
      if (we_m && wdst_m == id) return wval_m;
      if (we_e && wdst_e == id) return wval_e;
      return m_regs[id];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] <= DW'(i);
         x_icode <= 4'h1;
         x_srcA  <= 4'hF; x_srcB <= 4'hF; x_dstE <= 4'hF; x_dstM <= 4'hF;
         x_valA  <= '0;   x_valB <= '0;
      end else begin
         if (!e_stall) begin
            if (e_bubble) begin
               x_icode <= 4'h1;
               x_srcA  <= 4'hF; x_srcB <= 4'hF; x_dstE <= 4'hF; x_dstM <= 4'hF;
               x_valA  <= '0;   x_valB <= '0;
            end else begin
               x_icode <= d_icode;
               x_srcA  <= m_src_a(d_icode, d_rA);
               x_srcB  <= m_src_b(d_icode, d_rB);
               x_dstE  <= m_dst_e(d_icode, d_rB);
               x_dstM  <= m_dst_m(d_icode, d_rA);
               x_valA  <= m_rd(m_src_a(d_icode, d_rA));
               x_valB  <= m_rd(m_src_b(d_icode, d_rB));
            end
         end
         if (we_e && int'(wdst_e) < NR) m_regs[wdst_e] <= wval_e;
         if (we_m && int'(wdst_m) < NR) m_regs[wdst_m] <= wval_m;
      end
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model compare on every falling edge outside reset
   always @(negedge clk) begin
      if (en && !rst) begin
         check("m_icode", 64'(e_icode), 64'(x_icode));
         check("m_srcA",  64'(e_srcA),  64'(x_srcA));
         check("m_srcB",  64'(e_srcB),  64'(x_srcB));
         check("m_dstE",  64'(e_dstE),  64'(x_dstE));
         check("m_dstM",  64'(e_dstM),  64'(x_dstM));
         check("m_valA",  e_valA, x_valA);
         check("m_valB",  e_valB, x_valB);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
      d_icode = ic; d_rA = ra; d_rB = rb;
   endtask

   task automatic wr_e(input logic en_i, input logic [3:0] dst, input logic [DW-1:0] val);
      we_e = en_i; wdst_e = dst; wval_e = val;
   endtask

   task automatic wr_m(input logic en_i, input logic [3:0] dst, input logic [DW-1:0] val);
      we_m = en_i; wdst_m = dst; wval_m = val;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      drive(4'h0, 4'h0, 4'h0);
      e_stall = 1'b0; e_bubble = 1'b0;
      wr_e(1'b0, 4'h0, '0);
      wr_m(1'b0, 4'h0, '0);
      #2 rst = 1'b1;
      #1;
      check("rst_icode", 64'(e_icode), 64'h1);
      check("rst_srcA",  64'(e_srcA),  64'hF);
      check("rst_valA",  e_valA, 64'h0);
      #4 rst = 1'b0;
      en = 1'b1;

      // 1: OPq rA=2 rB=3 with index-initialised registers
      drive(4'h6, 4'h2, 4'h3);
      tick();
      check("t1_valA", e_valA, 64'h2);
      check("t1_valB", e_valB, 64'h3);
      check("t1_dstE", 64'(e_dstE), 64'h3);
      check("t1_dstM", 64'(e_dstM), 64'hF);

      // 2: pushq with same-cycle E write to %rsp
      drive(4'hA, 4'h7, 4'h0);
      wr_e(1'b1, 4'h4, 64'h100);
      tick();
      check("t2_valA", e_valA, 64'h7);
      check("t2_valB", e_valB, 64'h100);
      check("t2_dstE", 64'(e_dstE), 64'h4);
      wr_e(1'b0, 4'h0, '0);
      drive(4'h6, 4'h4, 4'h0);
      tick();
      check("t2_reg4", e_valA, 64'h100);

      // 3: both ports hit reg4, M wins in storage and bypass
      wr_e(1'b1, 4'h4, 64'hAA);
      wr_m(1'b1, 4'h4, 64'hBB);
      drive(4'h2, 4'h4, 4'h5);
      tick();
      check("t3_byp", e_valA, 64'hBB);
      check("t3_dstE", 64'(e_dstE), 64'h5);
      wr_e(1'b0, 4'h0, '0);
      wr_m(1'b0, 4'h0, '0);
      drive(4'h6, 4'h4, 4'h4);
      tick();
      check("t3_reg4a", e_valA, 64'hBB);
      check("t3_reg4b", e_valB, 64'hBB);

      // 4: stall, stall+bubble, bubble
      e_stall = 1'b1;
      drive(4'h3, 4'hF, 4'h9);
      tick();
      check("t4_hold1", 64'(e_icode), 64'h6);
      drive(4'h8, 4'h0, 4'h0);
      tick();
      check("t4_hold2", e_valA, 64'hBB);
      e_bubble = 1'b1;
      drive(4'h2, 4'h1, 4'h1);
      tick();
      check("t4_sb_dstE", 64'(e_dstE), 64'h4);
      e_stall = 1'b0;
      tick();
      check("t4_bub_ic",   64'(e_icode), 64'h1);
      check("t4_bub_srcA", 64'(e_srcA),  64'hF);
      check("t4_bub_dstE", 64'(e_dstE),  64'hF);
      check("t4_bub_valB", e_valB, 64'h0);
      e_bubble = 1'b0;

      // 5: RNONE / out-of-range writes dropped; mrmovq with rA=F
      wr_e(1'b1, 4'hF, 64'h55);
      wr_m(1'b1, 4'hE, 64'h66);
      drive(4'h5, 4'hF, 4'hE);
      tick();
      check("t5_dstM", 64'(e_dstM), 64'hF);
      check("t5_valA", e_valA, 64'h0);
      check("t5_valB", e_valB, 64'h0);
      wr_e(1'b0, 4'h0, '0);
      wr_m(1'b0, 4'h0, '0);
      drive(4'h6, 4'hD, 4'h0);
      tick();
      check("t5_reg13", e_valA, 64'hD);
      check("t5_reg0",  e_valB, 64'h0);

      // unknown icode
      drive(4'hC, 4'h2, 4'h3);
      tick();
      check("unk_srcB", 64'(e_srcB), 64'hF);
      check("unk_valA", e_valA, 64'h0);

      // two ports, different dsts, both land; ret reads %rsp
      wr_e(1'b1, 4'h1, 64'h11);
      wr_m(1'b1, 4'h2, 64'h22);
      drive(4'h9, 4'h0, 4'h0);
      tick();
      check("ret_valA", e_valA, 64'hBB);
      wr_e(1'b0, 4'h0, '0);
      wr_m(1'b0, 4'h0, '0);
      drive(4'h6, 4'h1, 4'h2);
      tick();
      check("dual_r1", e_valA, 64'h11);
      check("dual_r2", e_valB, 64'h22);

      // 6: async reset between edges, pending write blocked
      wr_e(1'b1, 4'h3, 64'h99);
      #2 rst = 1'b1;
      #1;
      check("t6_icode", 64'(e_icode), 64'h1);
      check("t6_valA",  e_valA, 64'h0);
      check("t6_srcA",  64'(e_srcA), 64'hF);
      check("t6_dstE",  64'(e_dstE), 64'hF);
      #8;
      wr_e(1'b0, 4'h0, '0);
      rst = 1'b0;
      drive(4'h6, 4'h4, 4'h3);
      tick();
      check("t6_reg4", e_valA, 64'h4);
      check("t6_reg3", e_valB, 64'h3);
      drive(4'h6, 4'h1, 4'h2);
      tick();
      check("t6_reg1", e_valA, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
